dlx_data_sram: RTL
==================

Name: dlx_data_sram

Overview:
- Responder end of the pipelined DLX core's data-memory bus (sramA/sramData/sramWe/sramRe), replacing the behavioural SRAM model with a synthesizable, word-addressed data memory.
- Services MEM-stage loads combinationally in the same cycle, so the core samples load data at the following edge.
- Posts stores through a one-entry write buffer with read-after-write bypass.
- Zero-clears the array after reset and keeps statistics and sticky error flags for debug.

Parameters:
- ADDR_W, 10, word-address width; array depth is 2**ADDR_W words.
- DATA_W, 32, data word width; must match the core's sramData width.
- CNT_W, 16, width of the saturating access counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- sramA  input  32  byte address from EX/MEM ALU result.
- sramData  inout  DATA_W  bidirectional data; driven by this block only on a valid read.
- sramWe  input  1  write strobe from EX/MEM.
- sramRe  input  1  read strobe from EX/MEM.
- mem_ready  output  1  high once post-reset clear is complete.
- rd_count  output  CNT_W  completed reads, saturating.
- wr_count  output  CNT_W  accepted writes, saturating.
- err_oob  output  1  sticky; access above the array.
- err_conflict  output  1  sticky; sramWe and sramRe asserted together.
- err_align  output  1  sticky; access with sramA[1:0] != 0.

Behaviour:
- Reset (rst low at an edge):
  - FSM enters CLEAR; clear index = 0; write buffer invalid.
  - rd_count, wr_count, err_* = 0; mem_ready = 0.
  - Array contents are not guaranteed until CLEAR finishes.
- FSM:
  - CLEAR: writes 0 to word[clear index], one word per cycle. At index 2**ADDR_W-1, the next state is READY and mem_ready goes to 1. Clearing takes exactly 2**ADDR_W cycles after reset release.
  - READY: normal service. Stays in READY until reset.
  - rst low in any state, including mid-clear, restarts CLEAR at index 0.
- Address decode:
  - word index = sramA[ADDR_W+1:2].
  - Out of bounds when any bit of sramA[31:ADDR_W+2] is set.
  - Bits [1:0] are ignored for indexing; a nonzero value sets err_align and the access still proceeds.
- Read (READY, sramRe=1, sramWe=0):
  - sramData is driven combinationally in the same cycle.
  - Data comes from the write buffer if it is valid and its index matches; otherwise from the array.
  - Out of bounds: drives 0 and sets err_oob.
  - rd_count increments at the edge.
- Write (READY, sramWe=1, sramRe=0):
  - At the edge, if the buffer is valid, its data is committed to the array.
  - In the same edge, {index, sramData} is captured into the buffer.
  - Back-to-back writes to the same index: the later value wins.
  - A subsequent read in the next cycle sees the new value via bypass.
  - Out-of-bounds writes are dropped (no buffer load) and set err_oob.
  - wr_count increments only for in-bounds writes.
- Idle cycles in READY: a valid buffer drains to the array and becomes invalid.
- Conflict (sramWe=1, sramRe=1):
  - No drive, no write, no count update.
  - err_conflict set; the buffer still drains.
- sramData is high-Z at all times except a valid READY read, including during CLEAR and conflict cycles.
- Accesses during CLEAR: ignored, not counted, no error flags.
- Counters hold at 2**CNT_W-1; they never wrap.
- Sticky flags clear only on reset.

Decomposition:
- Shared DLX package holds:
  - Bus constants: DATA_W, word-offset width (2).
  - FSM state encoding: CLEAR, READY.
  - A function returning the word index and out-of-bounds bit from sramA.
- One sub-module, dlx_wbuf: the one-entry write buffer. It owns valid/index/data, drain enable, and the bypass compare/mux.
- The top level holds the array, FSM, counters, flags and tri-state driver.

Test Plan:
- Reset then idle, ADDR_W=4 -> mem_ready=0 for exactly 16 cycles, then 1; reads of words 0..15 return 0; sramData high-Z during clear.
- Write 0xDEADBEEF to 0x10, then read 0x10 next cycle -> 0xDEADBEEF via bypass; after 2 idle cycles, the read returns 0xDEADBEEF from the array; wr_count=1, rd_count=2.
- Writes 0x11111111 then 0x22222222 back-to-back to 0x20, then a read of 0x20 -> 0x22222222; a read of 0x24 -> 0.
- Write to 0x0000_1000 with ADDR_W=10 -> err_oob=1, wr_count unchanged; a read of the same address drives 0.
- sramWe=sramRe=1 for one cycle -> sramData high-Z, err_conflict=1, no count change; a read of 0x02 sets err_align and returns word 0.
- rst low mid-clear at index 7 -> mem_ready stays 0, clear restarts at 0, full 2**ADDR_W cycles; 65536 reads -> rd_count saturates at 0xFFFF.

Source files
------------

// File: rtl/dlx_data_sram_pkg.sv
// Shared DLX data-memory definitions: bus constants, FSM state encoding,
// and the byte-address to word-index / out-of-bounds decode helper.
package dlx_data_sram_pkg;

    localparam int BUS_DATA_W = 32;
    localparam int OFS_W      = 2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    typedef struct packed {
        logic        oob;
        logic [29:0] idx;
    } addr_dec_t;

    // idx is the full word address; callers keep the low aw bits.
    function automatic addr_dec_t dec_addr(
        input logic [31:0] a,
        input int          aw
    );
        addr_dec_t d;
        d.idx = a[31:OFS_W];
        d.oob = |(a >> (aw + OFS_W));
        return d;
    endfunction

endpackage

// File: rtl/dlx_wbuf.sv
// One-entry posted write buffer with read-after-write bypass.
// Ports: load/drain controls, captured index/data, commit port, bypass read.
import dlx_data_sram_pkg::*;

module dlx_wbuf #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = BUS_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_drain,
    input  logic [ADDR_W-1:0] i_idx,
    input  logic [DATA_W-1:0] i_data,
    input  logic [ADDR_W-1:0] i_rd_idx,
    input  logic [DATA_W-1:0] i_arr_data,
    output logic              o_commit,
    output logic [ADDR_W-1:0] o_idx,
    output logic [DATA_W-1:0] o_data,
    output logic [DATA_W-1:0] o_rd_data
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_data;
    logic              w_hit;

    // Any drain opportunity (including a new load) retires the old entry.
    assign o_commit = r_valid & i_drain;
    assign o_idx    = r_idx;
    assign o_data   = r_data;

    assign w_hit     = r_valid & (r_idx == i_rd_idx);
    assign o_rd_data = w_hit ? r_data : i_arr_data;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_idx   <= i_idx;
            r_data  <= i_data;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dlx_data_sram.sv
// Synthesizable word-addressed DLX data memory with post-reset clear,
// posted writes, saturating access counters and sticky error flags.
// Ports: clk/rst (sync, active-low), sramA/sramData/sramWe/sramRe bus,
// mem_ready, rd_count, wr_count, err_oob, err_conflict, err_align.
import dlx_data_sram_pkg::*;

module dlx_data_sram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = BUS_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       sramA,
    inout  wire  [DATA_W-1:0] sramData,
    input  logic              sramWe,
    input  logic              sramRe,
    output logic              mem_ready,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count,
    output logic              err_oob,
    output logic              err_conflict,
    output logic              err_align
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_idx;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [CNT_W-1:0]  r_rd_cnt;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic              r_err_oob;
    logic              r_err_cf;
    logic              r_err_al;

    addr_dec_t         w_dec;
    logic [ADDR_W-1:0] w_idx;
    logic              w_ready;
    logic              w_rd;
    logic              w_wr;
    logic              w_cf;
    logic              w_load;
    logic              w_drain;
    logic              w_acc;

    logic              w_commit;
    logic [ADDR_W-1:0] w_wb_idx;
    logic [DATA_W-1:0] w_wb_data;
    logic [DATA_W-1:0] w_arr_rd;
    logic [DATA_W-1:0] w_byp_rd;
    logic [DATA_W-1:0] w_rdata;

    logic              w_arr_we;
    logic [ADDR_W-1:0] w_arr_addr;
    logic [DATA_W-1:0] w_arr_data;

    assign w_dec   = dec_addr(sramA, ADDR_W);
    assign w_idx   = w_dec.idx[ADDR_W-1:0];
    assign w_ready = (r_state == ST_READY);

    assign w_rd    = w_ready & sramRe & ~sramWe;
    assign w_wr    = w_ready & sramWe & ~sramRe;
    assign w_cf    = w_ready & sramWe & sramRe;
    assign w_acc   = w_rd | w_wr;
    assign w_load  = w_wr & ~w_dec.oob;
    // Reads keep the entry; the bypass covers it.
    assign w_drain = w_ready & ~w_rd;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_CLEAR: begin
                if (&r_clr_idx) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                w_state_nxt = ST_READY;
            end
            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_clr_idx <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_idx <= r_clr_idx + 1'b1;
        end
    end

    dlx_wbuf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wbuf (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_load     (w_load),
        .i_drain    (w_drain),
        .i_idx      (w_idx),
        .i_data     (sramData),
        .i_rd_idx   (w_idx),
        .i_arr_data (w_arr_rd),
        .o_commit   (w_commit),
        .o_idx      (w_wb_idx),
        .o_data     (w_wb_data),
        .o_rd_data  (w_byp_rd)
    );

    // Single array write port shared by the clear sweep and buffer drain.
    assign w_arr_we   = (r_state == ST_CLEAR) | w_commit;
    assign w_arr_addr = (r_state == ST_CLEAR) ? r_clr_idx : w_wb_idx;
    assign w_arr_data = (r_state == ST_CLEAR) ? '0 : w_wb_data;

    always_ff @(posedge clk) begin
        if (w_arr_we) begin
            r_mem[w_arr_addr] <= w_arr_data;
        end
    end

    assign w_arr_rd = r_mem[w_idx];
    assign w_rdata  = w_dec.oob ? '0 : w_byp_rd;
    assign sramData = w_rd ? w_rdata : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_err_oob <= 1'b0;
            r_err_cf  <= 1'b0;
            r_err_al  <= 1'b0;
        end else begin
            if (w_rd && (r_rd_cnt != '1)) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            if (w_load && (r_wr_cnt != '1)) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
            if (w_acc && w_dec.oob) begin
                r_err_oob <= 1'b1;
            end
            if (w_acc && (sramA[1:0] != 2'b00)) begin
                r_err_al <= 1'b1;
            end
            if (w_cf) begin
                r_err_cf <= 1'b1;
            end
        end
    end

    assign mem_ready    = w_ready;
    assign rd_count     = r_rd_cnt;
    assign wr_count     = r_wr_cnt;
    assign err_oob      = r_err_oob;
    assign err_conflict = r_err_cf;
    assign err_align    = r_err_al;

endmodule
